accel_avg_filter: RTL and testbench
===================================

ACCEL_AVG_FILTER -- requirements
Module: accel_avg_filter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, log2 of the moving-average window (window = 4 samples).
REQ-002 SHALL have parameter THRESH, default 8'd64, the unsigned magnitude limit for the per-axis tilt flag.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, which is the SPI sclk domain.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid, input, 1 bit: one-cycle strobe meaning x_in/y_in/z_in hold a new sample.
REQ-006 SHALL have ports x_in, y_in, z_in, input, 8 bits each: signed two's-complement received X/Y/Z bytes.
REQ-007 SHALL have port clear, input, 1 bit: synchronous flush of the window.
REQ-008 SHALL have ports x_avg, y_avg, z_avg, output, 8 bits each: signed window averages.
REQ-009 SHALL have port avg_valid, output, 1 bit: one-cycle strobe meaning the averages were updated.
REQ-010 SHALL have port window_full, output, 1 bit: high when the window holds 2**DEPTH_LOG2 samples.
REQ-011 SHALL have port tilt, output, 3 bits, [0]=X [1]=Y [2]=Z: set when |avg| > THRESH.

Function
REQ-012 SHALL keep, per axis, a circular buffer of 2**DEPTH_LOG2 signed 8-bit entries, a shared write pointer and a running sum of width 8+DEPTH_LOG2.
REQ-013 SHALL use a two-state FSM: FILL (count < window) and RUN (count == window).
REQ-014 SHALL, on a sample_valid edge in FILL, store the sample, add it to the sum, increment count and advance the pointer.
REQ-015 SHALL, on a sample_valid edge in RUN, replace the oldest entry with the new sample and update sum = sum + new - oldest in the same edge.
REQ-016 SHALL wrap the write pointer modulo the window with no gap cycle.
REQ-017 SHALL transition FILL->RUN on the edge that stores the window-th sample; RUN SHALL be left only via clear or reset.
REQ-018 SHALL hold count saturated at the window size while in RUN.
REQ-019 SHALL compute each average as the arithmetic right shift of the sum by DEPTH_LOG2 (floor toward minus infinity).
REQ-020 SHALL guarantee that the sum never overflows and that the average always lies in [-128, 127].
REQ-021 SHALL register the averages and tilt on the clock edge after the sample edge, so latency is 1 cycle.
REQ-022 SHALL raise avg_valid for exactly that one cycle, and only when the sum covered a full window.
REQ-023 SHALL never pulse avg_valid while in FILL.
REQ-024 SHALL accept sample_valid on every cycle (back-to-back), with one avg_valid per accepted sample once full.
REQ-025 SHALL compute tilt[i] = (|avg_i| > THRESH), with |-128| treated as 128, and update it together with the averages.
REQ-026 SHALL hold x_avg, y_avg, z_avg and tilt between updates.
REQ-027 SHALL, when clear is high at an edge, zero count, pointer, sums, buffer, averages and tilt, enter FILL, and keep avg_valid low.
REQ-028 SHALL give clear priority when clear and sample_valid occur in the same cycle; that sample is dropped.

Reset
REQ-029 SHALL, while rst_n is low, immediately force FILL, count=0, pointer=0, sums=0, buffer entries=0, x_avg=y_avg=z_avg=0, tilt=0, avg_valid=0 and window_full=0.
REQ-030 SHALL discard any in-flight update when reset is asserted mid-stream and SHALL restart in FILL on deassertion.

Structure
REQ-031 SHALL take the sample typedef (signed 8-bit), the axis index enum (X, Y, Z) and NUM_AXES=3 from shared package accel_pkg.
REQ-032 SHALL implement per-axis buffer, sum and average in sub-module accel_axis_avg, instantiated three times, with the FSM, count and pointer shared in the top.

Verification
REQ-033 SHALL verify fill: X samples 4, 8, 12, 16 -> no avg_valid for the first 3, then avg_valid one cycle after the 4th with x_avg=10 and window_full=1.
REQ-034 SHALL verify sliding: a 5th sample X=20 -> x_avg=14 (sum 56), with the pointer wrapped to 1.
REQ-035 SHALL verify negative rounding: X samples -1, -1, -1, -2 -> x_avg=-2 (floor of -5/4).
REQ-036 SHALL verify extremes: four Y=-128 -> y_avg=-128 and tilt[1]=1; four Z=127 -> z_avg=127 and tilt[2]=1; four X=64 -> tilt[0]=0.
REQ-037 SHALL verify clear: clear with simultaneous sample_valid in RUN -> averages=0, window_full=0, sample dropped, and no avg_valid until 4 new samples.
REQ-038 SHALL verify reset: rst_n low for one cycle during back-to-back samples -> all outputs 0 with no clock edge needed, then normal fill resumes.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types for the accelerometer averaging filter.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package accel_pkg;

  localparam int NUM_AXES = 3;

  typedef logic signed [7:0] sample_t;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } avg_state_e;

  // Magnitude compare with -128 taken as +128 (9-bit magnitude avoids wrap).
  function automatic logic exceeds_thresh(input sample_t v, input logic [7:0] th);
    logic [8:0] mag;
    mag = v[7] ? (9'd0 - {1'b1, v}) : {1'b0, v};
    return mag > {1'b0, th};
  endfunction

endpackage

// File: rtl/accel_axis_avg.sv
// One axis: circular sample buffer, running sum, registered average and tilt flag.
// Latency: average/tilt registered on the same edge that accepts the sample (visible next cycle).
// Backpressure: none; accepts a sample every cycle.
module accel_axis_avg
  import accel_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [7:0]  THRESH     = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  replace,
  input  logic                  publish,
  input  logic [DEPTH_LOG2-1:0] wr_ptr,
  input  sample_t               sample_in,
  output sample_t               avg,
  output logic                  tilt
);

  localparam int WIN = 1 << DEPTH_LOG2;
  localparam int SW  = 8 + DEPTH_LOG2;

  sample_t               ring [WIN];
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  new_ext;
  logic signed [SW-1:0]  old_ext;
  sample_t               avg_next;

  // Next running sum: add the new sample, and drop the oldest once the window is full.
  always_comb begin
    new_ext  = {{DEPTH_LOG2{sample_in[7]}}, sample_in};
    old_ext  = {{DEPTH_LOG2{ring[wr_ptr][7]}}, ring[wr_ptr]};
    sum_next = replace ? (sum + new_ext - old_ext) : (sum + new_ext);
    // The top 8 bits of the sum are exactly sum >>> DEPTH_LOG2 (floor toward -inf);
    // a full window of 8-bit samples keeps that slice within [-128, 127].
    avg_next = sample_t'(sum_next[SW-1:DEPTH_LOG2]);
  end

  // Buffer, sum, average and tilt state; clear flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) ring[i] <= '0;
      sum  <= '0;
      avg  <= '0;
      tilt <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < WIN; i++) ring[i] <= '0;
      sum  <= '0;
      avg  <= '0;
      tilt <= 1'b0;
    end else if (wr_en) begin
      ring[wr_ptr] <= sample_in;
      sum          <= sum_next;
      if (publish) begin
        avg  <= avg_next;
        tilt <= exceeds_thresh(avg_next, THRESH);
      end
    end
  end

endmodule

// File: rtl/accel_avg_filter.sv
// Three-axis moving-average filter with per-axis tilt flags for SPI accelerometer samples.
// Latency: 1 cycle from the sample_valid strobe to avg_valid and the updated averages.
// Backpressure: none; sample_valid may be asserted every cycle, clear drops a coincident sample.
module accel_avg_filter
  import accel_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [7:0]  THRESH     = 8'd64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  sample_t             x_in,
  input  sample_t             y_in,
  input  sample_t             z_in,
  input  logic                clear,
  output sample_t             x_avg,
  output sample_t             y_avg,
  output sample_t             z_avg,
  output logic                avg_valid,
  output logic                window_full,
  output logic [NUM_AXES-1:0] tilt
);

  localparam int                WIN_I = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] WIN  = WIN_I[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LAST = WIN - 1'b1;

  avg_state_e              state;
  avg_state_e              next_state;
  logic [DEPTH_LOG2:0]     count;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic                    accept;
  logic                    publish;
  logic                    replace;
  logic                    tilt_x;
  logic                    tilt_y;
  logic                    tilt_z;

  // Next-state and per-sample control; clear wins over a coincident sample.
  always_comb begin
    next_state = state;
    accept     = sample_valid && !clear;
    replace    = 1'b0;
    publish    = 1'b0;
    if (clear) begin
      next_state = ST_FILL;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept && count == LAST) begin
            next_state = ST_RUN;
            publish    = 1'b1;
          end
        end
        ST_RUN: begin
          replace = 1'b1;
          publish = accept;
        end
        default: next_state = ST_FILL;
      endcase
    end
  end

  // State, fill count, shared write pointer and the one-cycle avg_valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      count     <= '0;
      wr_ptr    <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      state     <= ST_FILL;
      count     <= '0;
      wr_ptr    <= '0;
      avg_valid <= 1'b0;
    end else begin
      state     <= next_state;
      avg_valid <= publish;
      if (accept) begin
        // Pointer is DEPTH_LOG2 bits wide, so it wraps modulo the window on its own.
        wr_ptr <= wr_ptr + 1'b1;
        if (state == ST_FILL) count <= count + 1'b1;
      end
    end
  end

  assign window_full = (state == ST_RUN);

  accel_axis_avg #(.DEPTH_LOG2(DEPTH_LOG2), .THRESH(THRESH)) u_axis_x (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(accept), .replace(replace),
    .publish(publish), .wr_ptr(wr_ptr), .sample_in(x_in), .avg(x_avg), .tilt(tilt_x)
  );

  accel_axis_avg #(.DEPTH_LOG2(DEPTH_LOG2), .THRESH(THRESH)) u_axis_y (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(accept), .replace(replace),
    .publish(publish), .wr_ptr(wr_ptr), .sample_in(y_in), .avg(y_avg), .tilt(tilt_y)
  );

  accel_axis_avg #(.DEPTH_LOG2(DEPTH_LOG2), .THRESH(THRESH)) u_axis_z (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(accept), .replace(replace),
    .publish(publish), .wr_ptr(wr_ptr), .sample_in(z_in), .avg(z_avg), .tilt(tilt_z)
  );

  assign tilt[AXIS_X] = tilt_x;
  assign tilt[AXIS_Y] = tilt_y;
  assign tilt[AXIS_Z] = tilt_z;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Directed bench for accel_avg_filter: fill, slide, rounding, extremes, clear and reset.
// Latency: checks sampled 1 time unit after the capturing edge.
// Backpressure: n/a.
module tb_accel_avg_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] x_in, y_in, z_in;
  logic       clear;
  logic [7:0] x_avg, y_avg, z_avg;
  logic       avg_valid;
  logic       window_full;
  logic [2:0] tilt;

  int checks = 0;
  int fails  = 0;

  accel_avg_filter dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .clear(clear),
    .x_avg(x_avg), .y_avg(y_avg), .z_avg(z_avg),
    .avg_valid(avg_valid), .window_full(window_full), .tilt(tilt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    x_in = x; y_in = y; z_in = z;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, x_avg, 8'h00);
    chk({tag, "_y"}, y_avg, 8'h00);
    chk({tag, "_z"}, z_avg, 8'h00);
    chk({tag, "_vld"}, {7'd0, avg_valid}, 8'h00);
    chk({tag, "_full"}, {7'd0, window_full}, 8'h00);
    chk({tag, "_tilt"}, {5'd0, tilt}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; clear = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #1;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill: 4, 8, 12, 16 -> 10
    send(8'd4, 8'd0, 8'd0);
    chk("fill1_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd8, 8'd0, 8'd0);
    chk("fill2_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd12, 8'd0, 8'd0);
    chk("fill3_vld", {7'd0, avg_valid}, 8'h00);
    chk("fill3_full", {7'd0, window_full}, 8'h00);
    send(8'd16, 8'd0, 8'd0);
    chk("fill4_vld", {7'd0, avg_valid}, 8'h01);
    chk("fill4_x", x_avg, 8'd10);
    chk("fill4_full", {7'd0, window_full}, 8'h01);
    step();
    chk("idle_vld", {7'd0, avg_valid}, 8'h00);
    chk("idle_hold_x", x_avg, 8'd10);

    // Slide: 5th sample 20 -> sum 56 -> 14, pointer wrapped to 1
    send(8'd20, 8'd0, 8'd0);
    chk("slide_vld", {7'd0, avg_valid}, 8'h01);
    chk("slide_x", x_avg, 8'd14);
    chk("slide_ptr", {6'd0, dut.wr_ptr}, 8'd1);

    // Plain clear, then negative rounding: -1,-1,-1,-2 -> floor(-5/4) = -2
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all_zero("clear");
    send(8'hFF, 8'd0, 8'd0);
    send(8'hFF, 8'd0, 8'd0);
    send(8'hFF, 8'd0, 8'd0);
    send(8'hFE, 8'd0, 8'd0);
    chk("neg_vld", {7'd0, avg_valid}, 8'h01);
    chk("neg_x", x_avg, 8'hFE);
    chk("neg_tilt", {5'd0, tilt}, 8'h00);

    // Extremes: X=64 (not above 64), Y=-128, Z=127
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd64, 8'h80, 8'h7F);
    chk("ext_vld", {7'd0, avg_valid}, 8'h01);
    chk("ext_x", x_avg, 8'd64);
    chk("ext_y", y_avg, 8'h80);
    chk("ext_z", z_avg, 8'h7F);
    chk("ext_tilt", {5'd0, tilt}, 8'b0000_0110);

    // Clear with a coincident sample in RUN: sample dropped
    x_in = 8'd100; y_in = 8'd100; z_in = 8'd100;
    sample_valid = 1'b1; clear = 1'b1;
    step();
    sample_valid = 1'b0; clear = 1'b0;
    chk_all_zero("clr_smp");
    send(8'd8, 8'd0, 8'd0);
    chk("refill1_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd8, 8'd0, 8'd0);
    chk("refill2_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd8, 8'd0, 8'd0);
    chk("refill3_vld", {7'd0, avg_valid}, 8'h00);
    chk("refill3_full", {7'd0, window_full}, 8'h00);
    send(8'd8, 8'd0, 8'd0);
    chk("refill4_vld", {7'd0, avg_valid}, 8'h01);
    chk("refill4_x", x_avg, 8'd8);

    // Back-to-back samples in RUN, then async reset mid-cycle
    x_in = 8'd12; y_in = 8'd4; z_in = 8'd0;
    sample_valid = 1'b1;
    step();
    chk("b2b1_vld", {7'd0, avg_valid}, 8'h01);
    chk("b2b1_x", x_avg, 8'd9);
    step();
    chk("b2b2_vld", {7'd0, avg_valid}, 8'h01);
    chk("b2b2_x", x_avg, 8'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal fill after reset: 2, 2, 2, 6 -> 3
    send(8'd2, 8'd0, 8'd0);
    chk("post1_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd2, 8'd0, 8'd0);
    send(8'd2, 8'd0, 8'd0);
    chk("post3_vld", {7'd0, avg_valid}, 8'h00);
    send(8'd6, 8'd0, 8'd0);
    chk("post4_vld", {7'd0, avg_valid}, 8'h01);
    chk("post4_x", x_avg, 8'd3);
    chk("post4_full", {7'd0, window_full}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
